visitor_mux_arbiter: RTL and testbench
======================================

Name: visitor_mux_arbiter

Overview:
Arbitrates entry and exit sensor events onto the shared 2:1 mux path of the bidirectional visitor counter. It synchronises both sensors, latches pending events, grants one event per slot with round-robin priority, and drives the mux select. It owns the visitor occupancy count with saturation, overflow and underflow flags, and sits between the raw sensor inputs and the mux/display datapath.

Parameters:
CNT_W, 8, width of occupancy count
MAX_COUNT, 99, occupancy ceiling; must be less than 2**CNT_W
HOLD_CYCLES, 2, cycles sel is held stable after a grant before the next arbitration (0 allowed)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  reset, asynchronous, active-high
sens_in  in  1  entry sensor level, asynchronous to clk
sens_out  in  1  exit sensor level, asynchronous to clk
sel  out  1  mux select (0 = entry path / i0, 1 = exit path / i1), registered
grant_vld  out  1  one-cycle pulse: the event selected by sel is being serviced
cnt  out  CNT_W  current occupancy, registered
full  out  1  cnt == MAX_COUNT
empty  out  1  cnt == 0
ovf  out  1  one-cycle pulse: entry granted while full, so it is dropped
unf  out  1  one-cycle pulse: exit granted while empty, so it is dropped
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, immediate): sel=0, grant_vld=0, cnt=0, ovf=0, unf=0, busy=0, full=0, empty=1. Synchronisers, pending flags and FSM are cleared, and last_sel=1 so entry wins the first tie. Events pending when reset asserts are discarded.
- Sync: each sensor passes through a 2-flop synchroniser. evt_x is a rising edge of the synchronised value (sync2=1, previous=0). A level held high produces exactly one event.
- Pending: pend_x is set on evt_x and cleared at the edge where x is granted. If evt_x arrives in the same cycle the clear happens, pend_x stays set. A second evt_x while pend_x is already set merges into it and is not counted twice.
- FSM has three states: IDLE, GRANT and HOLD.
  - IDLE to GRANT happens when pend_in or pend_out is set. With one pending, that one is chosen. With both pending, the source opposite last_sel is chosen.
  - At the IDLE-to-GRANT edge the following update together: sel = chosen source, last_sel = chosen, grant_vld=1, chosen pend cleared.
    - Entry: cnt+1 if cnt<MAX_COUNT, otherwise cnt unchanged and ovf=1.
    - Exit: cnt-1 if cnt>0, otherwise cnt unchanged and unf=1.
  - GRANT lasts one cycle. It moves to HOLD if HOLD_CYCLES>0, otherwise to IDLE. grant_vld, ovf and unf drop at the exit edge.
  - HOLD lasts exactly HOLD_CYCLES cycles (down-counter), then returns to IDLE.
- sel changes only at the IDLE-to-GRANT edge and is otherwise held, including through IDLE.
- busy=1 in GRANT and HOLD.
- Latency: a sensor rise first sampled at edge E0 gives evt in cycle E1 to E2, pend at E2, and grant_vld/cnt visible after E3, provided the FSM is IDLE.
- Sustained alternating requests are strictly alternated. Minimum spacing between grants is HOLD_CYCLES+2 cycles.
- full and empty are combinational from cnt. cnt never wraps.

Decomposition:
- Shared package visitor_pkg holds:
  - state enum {IDLE, GRANT, HOLD}
  - constants SEL_ENTRY=1'b0 and SEL_EXIT=1'b1
- One sub-module, sync_edge_det: 2-flop synchroniser plus rising-edge detector, with the same clk/rst. It is instantiated once per sensor.

Test Plan:
- Reset then single sens_in pulse (high 5 cycles) -> exactly one grant_vld pulse 3 cycles after the sampling edge, sel=0, cnt 0→1, empty falls.
- sens_in and sens_out rise on the same cycle from reset -> entry granted first (sel=0, cnt=1), exit granted HOLD_CYCLES+2 cycles later (sel=1, cnt=0).
- sens_out pulse with cnt=0 -> grant_vld with sel=1, unf pulses for 1 cycle, cnt stays 0.
- Drive 99 entries, then a 100th -> full=1 after the 99th, 100th gives ovf=1 and cnt stays 99; next exit gives cnt=98, full=0.
- Two sens_in pulses inside one busy window -> merged into a single grant, cnt +1 only.
- Assert rst during HOLD with pend_out set -> all outputs return to reset values immediately, and no grant occurs after rst deasserts.

Source files
------------

// File: rtl/visitor_pkg.sv
// visitor_pkg: types and constants shared by the visitor counter arbiter.
//   state_t   : arbiter FSM states
//   SEL_ENTRY : mux select for the entry path (i0)
//   SEL_EXIT  : mux select for the exit path (i1)
package visitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic SEL_ENTRY = 1'b0;
  localparam logic SEL_EXIT  = 1'b1;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchroniser for an asynchronous level input,
// followed by a rising-edge detector on the synchronised value.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   din : asynchronous level input
//   evt : single-cycle pulse on each synchronised 0->1 transition
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic evt
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign evt = s2 & ~prev;

endmodule

// File: rtl/visitor_mux_arbiter.sv
// visitor_mux_arbiter: arbitrates entry/exit sensor events onto the shared
// 2:1 mux path and maintains the saturating occupancy count.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   sens_in   : entry sensor level (asynchronous)
//   sens_out  : exit sensor level (asynchronous)
//   sel       : registered mux select (0 = entry/i0, 1 = exit/i1)
//   grant_vld : one-cycle pulse, the event selected by sel is serviced
//   cnt       : registered occupancy
//   full      : cnt == MAX_COUNT
//   empty     : cnt == 0
//   ovf       : one-cycle pulse, entry dropped because count was full
//   unf       : one-cycle pulse, exit dropped because count was empty
//   busy      : arbiter in GRANT or HOLD
module visitor_mux_arbiter
  import visitor_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MAX_COUNT   = 99,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sens_in,
  input  logic             sens_out,
  output logic             sel,
  output logic             grant_vld,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf,
  output logic             busy
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD =
    (HOLD_CYCLES != 0) ? HW'(HOLD_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          last_sel;
  logic          pend_in;
  logic          pend_out;
  logic          evt_in;
  logic          evt_out;
  logic          grant_now;
  logic          choose_exit;
  logic          clr_in;
  logic          clr_out;

  sync_edge_det u_sync_in (
    .clk (clk),
    .rst (rst),
    .din (sens_in),
    .evt (evt_in)
  );

  sync_edge_det u_sync_out (
    .clk (clk),
    .rst (rst),
    .din (sens_out),
    .evt (evt_out)
  );

  // On a tie the source opposite the previous grant wins.
  always_comb begin
    grant_now   = 1'b0;
    choose_exit = SEL_ENTRY;
    if (state == IDLE && (pend_in || pend_out)) begin
      grant_now = 1'b1;
      if (pend_in && pend_out) choose_exit = ~last_sel;
      else                     choose_exit = pend_out;
    end
    clr_in  = grant_now & (choose_exit == SEL_ENTRY);
    clr_out = grant_now & (choose_exit == SEL_EXIT);
  end

  // A new event in the clear cycle keeps the flag set; repeats merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_in  <= 1'b0;
      pend_out <= 1'b0;
    end else begin
      pend_in  <= (pend_in  & ~clr_in)  | evt_in;
      pend_out <= (pend_out & ~clr_out) | evt_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_now) state <= GRANT;
        end
        GRANT: begin
          if (HOLD_CYCLES != 0) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) state <= IDLE;
          else                hold_cnt <= hold_cnt - HW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= SEL_ENTRY;
      last_sel  <= SEL_EXIT;
      grant_vld <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      cnt       <= '0;
    end else begin
      grant_vld <= grant_now;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      if (grant_now) begin
        sel      <= choose_exit;
        last_sel <= choose_exit;
        if (choose_exit == SEL_EXIT) begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else           unf <= 1'b1;
        end else begin
          if (cnt != MAX_C) cnt <= cnt + CNT_W'(1);
          else              ovf <= 1'b1;
        end
      end
    end
  end

  assign full  = (cnt == MAX_C);
  assign empty = (cnt == '0);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_visitor_mux_arbiter.sv
module tb_visitor_mux_arbiter;

  localparam int CNT_W = 8;
  localparam int MAXC  = 99;
  localparam int H     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             sens_in;
  logic             sens_out;
  logic             sel;
  logic             grant_vld;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;
  logic             busy;

  always #5 clk = ~clk;

  visitor_mux_arbiter #(
    .CNT_W       (CNT_W),
    .MAX_COUNT   (MAXC),
    .HOLD_CYCLES (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sens_in   (sens_in),
    .sens_out  (sens_out),
    .sel       (sel),
    .grant_vld (grant_vld),
    .cnt       (cnt),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .unf       (unf),
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: sensor sample history, pending flags, and the earliest
  // edge at which the next grant may happen (last grant + H + 2).
  int        m_cnt;
  bit        m_sel, m_last, m_pin, m_pout, m_gv, m_ovf, m_unf, m_busy;
  int        cyc = 0;
  int        next_free;
  int        last_grant;
  bit [2:0]  hin, hout;   // [0]=sample one edge ago, [1]=two, [2]=three
  int        entry_seen = 0;
  int        exit_seen  = 0;
  int        ovf_seen   = 0;

  always @(posedge clk) begin
    bit ei, eo, cx;
    if (rst) begin
      m_cnt = 0; m_sel = 0; m_last = 1; m_pin = 0; m_pout = 0;
      m_gv = 0; m_ovf = 0; m_unf = 0; m_busy = 0;
      hin = '0; hout = '0;
      next_free = 0; last_grant = -1000;
    end else begin
      ei = hin[1] & ~hin[2];
      eo = hout[1] & ~hout[2];
      hin  = {hin[1:0], sens_in};
      hout = {hout[1:0], sens_out};
      m_gv = 0; m_ovf = 0; m_unf = 0;
      if (cyc >= next_free && (m_pin || m_pout)) begin
        cx = (m_pin && m_pout) ? !m_last : m_pout;
        m_sel = cx; m_last = cx; m_gv = 1;
        if (cx) begin
          m_pout = 0;
          if (m_cnt > 0) m_cnt = m_cnt - 1; else m_unf = 1;
        end else begin
          m_pin = 0;
          if (m_cnt < MAXC) m_cnt = m_cnt + 1; else m_ovf = 1;
        end
        last_grant = cyc;
        next_free  = cyc + H + 2;
      end
      m_pin  = m_pin  | ei;
      m_pout = m_pout | eo;
      m_busy = (cyc >= last_grant) && (cyc <= last_grant + H);
    end
    cyc++;
    #1;
    chk("grant_vld", 32'(grant_vld), 32'(m_gv));
    chk("sel",       32'(sel),       32'(m_sel));
    chk("cnt",       32'(cnt),       32'(m_cnt));
    chk("ovf",       32'(ovf),       32'(m_ovf));
    chk("unf",       32'(unf),       32'(m_unf));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("full",      32'(full),      32'(m_cnt == MAXC));
    chk("empty",     32'(empty),     32'(m_cnt == 0));
    if (grant_vld === 1'b1) begin
      if (sel) exit_seen++; else entry_seen++;
    end
    if (ovf === 1'b1) ovf_seen++;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; sens_in = 1'b0; sens_out = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_in(input int hi, input int lo);
    @(negedge clk); sens_in = 1'b1;
    repeat (hi) @(negedge clk);
    sens_in = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic pulse_out(input int hi, input int lo);
    @(negedge clk); sens_out = 1'b1;
    repeat (hi) @(negedge clk);
    sens_out = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  int e0, x0, o0;

  initial begin
    rst = 1'b1; sens_in = 1'b0; sens_out = 1'b0;
    edges(1);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_cnt",   32'(cnt),   32'd0);
    @(negedge clk); rst = 1'b0;

    // Single entry pulse: grant three edges after the sampling edge.
    @(negedge clk); sens_in = 1'b1;
    edges(3);
    chk("single_no_early_grant", 32'(grant_vld), 32'd0);
    edges(1);
    chk("single_grant", 32'(grant_vld), 32'd1);
    chk("single_sel",   32'(sel),       32'd0);
    chk("single_cnt",   32'(cnt),       32'd1);
    chk("single_empty", 32'(empty),     32'd0);
    repeat (2) @(negedge clk);
    sens_in = 1'b0;
    edges(10);
    chk("single_one_grant", 32'(entry_seen), 32'd1);

    // Simultaneous rise from reset: entry first, exit H+2 later.
    do_reset();
    @(negedge clk); sens_in = 1'b1; sens_out = 1'b1;
    edges(4);
    chk("tie_first_sel", 32'(sel),       32'd0);
    chk("tie_first_cnt", 32'(cnt),       32'd1);
    edges(H + 1);
    chk("tie_gap_quiet", 32'(grant_vld), 32'd0);
    edges(1);
    chk("tie_second_gv",  32'(grant_vld), 32'd1);
    chk("tie_second_sel", 32'(sel),       32'd1);
    chk("tie_second_cnt", 32'(cnt),       32'd0);
    @(negedge clk); sens_in = 1'b0; sens_out = 1'b0;
    edges(6);

    // Exit while empty.
    @(negedge clk); sens_out = 1'b1;
    edges(4);
    chk("unf_pulse", 32'(unf), 32'd1);
    chk("unf_sel",   32'(sel), 32'd1);
    chk("unf_cnt",   32'(cnt), 32'd0);
    edges(1);
    chk("unf_drop",  32'(unf), 32'd0);
    @(negedge clk); sens_out = 1'b0;
    edges(4);

    // Fill to the ceiling, then one more.
    for (int i = 0; i < MAXC; i++) pulse_in(3, 3);
    edges(6);
    chk("fill_cnt",  32'(cnt),  32'd99);
    chk("fill_full", 32'(full), 32'd1);
    o0 = ovf_seen;
    pulse_in(3, 3);
    edges(6);
    chk("ovf_count", 32'(ovf_seen - o0), 32'd1);
    chk("ovf_cnt",   32'(cnt),           32'd99);
    pulse_out(3, 3);
    edges(6);
    chk("after_exit_cnt",  32'(cnt),  32'd98);
    chk("after_exit_full", 32'(full), 32'd0);

    // Two entry pulses while the arbiter is busy with an exit merge.
    e0 = entry_seen; x0 = exit_seen;
    @(negedge clk); sens_out = 1'b1;
    @(negedge clk); sens_in = 1'b1;
    @(negedge clk); sens_in = 1'b0;
    @(negedge clk); sens_in = 1'b1;
    @(negedge clk); sens_in = 1'b0;
    @(negedge clk); sens_out = 1'b0;
    edges(14);
    chk("merge_entry_grants", 32'(entry_seen - e0), 32'd1);
    chk("merge_exit_grants",  32'(exit_seen - x0),  32'd1);
    chk("merge_cnt",          32'(cnt),             32'd98);

    // Reset asserted in HOLD with an exit pending.
    @(negedge clk); sens_in = 1'b1;
    @(negedge clk); sens_out = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst_gv",    32'(grant_vld), 32'd0);
    chk("rst_cnt",   32'(cnt),       32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_sel",   32'(sel),       32'd0);
    chk("rst_empty", 32'(empty),     32'd1);
    chk("rst_full",  32'(full),      32'd0);
    sens_in = 1'b0; sens_out = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e0 = entry_seen; x0 = exit_seen;
    edges(12);
    chk("rst_no_grant", 32'(entry_seen + exit_seen - e0 - x0), 32'd0);

    // Random traffic: entry-biased first half, exit-biased second half.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      if (c < 2000) begin
        if ($urandom_range(0, 2) == 0) sens_in  = ~sens_in;
        if ($urandom_range(0, 7) == 0) sens_out = ~sens_out;
      end else begin
        if ($urandom_range(0, 7) == 0) sens_in  = ~sens_in;
        if ($urandom_range(0, 2) == 0) sens_out = ~sens_out;
      end
    end
    @(negedge clk); rst = 1'b0; sens_in = 1'b0; sens_out = 1'b0;
    edges(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
